// File: rtl/seq_pkg.sv
// seq_pkg: shared state encoding and default test pattern for seq_generator
package seq_pkg;
   typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;
   localparam logic [4:0] DEFAULT_PATTERN = 5'b10110;
   localparam int DEFAULT_LENGTH = 5;
endpackage

// File: rtl/seq_generator.sv
// seq_generator: serialises a latched pattern MSB-first, with optional gapped repeats
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   start, abort        : begin a transmission (IDLE only) / terminate any transmission
//   pattern, length     : bits to send and how many (bit length-1 goes first)
//   repeat_count        : number of transmissions, 0 behaves as 1
//   x, x_valid          : serial bit and its qualifier (x forced 0 when not valid)
//   busy, done, err     : not-IDLE flag, end-of-job pulse, rejected-start pulse
module seq_generator
   import seq_pkg::*;
#(
   parameter int MAX_LEN    = 8,
   parameter int GAP_CYCLES = 1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic               abort,
   input  logic [MAX_LEN-1:0] pattern,
   input  logic [4:0]         length,
   input  logic [3:0]         repeat_count,
   output logic               x,
   output logic               x_valid,
   output logic               busy,
   output logic               done,
   output logic               err
);
   state_t state, state_n;
   logic [MAX_LEN-1:0] pat_q, pat_n, src, shifted;
   logic [4:0] len_q, len_n, bit_q, bit_n;
   logic [3:0] rep_q, rep_n, gap_q, gap_n;
   logic x_n, x_valid_n, busy_n, done_n, err_n, len_ok;
   assign len_ok = length != 5'd0 && length <= 5'(MAX_LEN);
   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         pat_q   <= '0;
         len_q   <= '0;
         rep_q   <= '0;
         bit_q   <= '0;
         gap_q   <= '0;
         x       <= 1'b0;
         x_valid <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         state   <= state_n;
         pat_q   <= pat_n;
         len_q   <= len_n;
         rep_q   <= rep_n;
         bit_q   <= bit_n;
         gap_q   <= gap_n;
         x       <= x_n;
         x_valid <= x_valid_n;
         busy    <= busy_n;
         done    <= done_n;
         err     <= err_n;
      end
   end
   // bit_q is the index of the bit currently on x; outputs are computed
   // from the next state so they appear registered with the state change
   always_comb begin
      state_n = state;
      pat_n   = pat_q;
      len_n   = len_q;
      rep_n   = rep_q;
      bit_n   = bit_q;
      gap_n   = gap_q;
      src     = pat_q;
      err_n   = 1'b0;
      case (state)
         IDLE: if (start && !abort) begin
            if (len_ok) begin
               state_n = SHIFT;
               pat_n   = pattern;
               len_n   = length;
               rep_n   = repeat_count == 4'd0 ? 4'd1 : repeat_count;
               bit_n   = length - 5'd1;
               src     = pattern;
            end else err_n = 1'b1;
         end
         SHIFT: if (bit_q == 5'd0) begin
            if (rep_q > 4'd1) begin
               state_n = GAP;
               rep_n   = rep_q - 4'd1;
               gap_n   = 4'(GAP_CYCLES - 1);
            end else state_n = DONE;
         end else bit_n = bit_q - 5'd1;
         GAP: if (gap_q == 4'd0) begin
            state_n = SHIFT;
            bit_n   = len_q - 5'd1;
         end else gap_n = gap_q - 4'd1;
         default: state_n = IDLE;
      endcase
      if (abort && state != IDLE) state_n = IDLE;
      shifted   = src >> bit_n;
      x_valid_n = state_n == SHIFT;
      x_n       = x_valid_n & shifted[0];
      busy_n    = state_n != IDLE;
      done_n    = state_n == DONE;
   end
endmodule
